// File: rtl/transmit_engine.sv
// Serial transmit engine: latches a configurable 7/8-bit frame with optional
// parity and shifts it out LSB-first as a fixed 11-bit frame at a selectable bit rate.
`timescale 1ns/1ps
module transmit_engine (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] baud,
  input  logic       eight,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic [7:0] out_port,
  input  logic       load,
  output logic       tx,
  output logic       txrdy
);

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [10:0] shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [18:0] baud_cnt_q, baud_cnt_d;
  logic [18:0] bit_time_q, bit_time_d;
  logic [18:0] sel_time_s;
  logic        bit_end_s;

  function automatic logic [18:0] bit_time_f(input logic [3:0] sel);
    case (sel)
      4'd0:    return 19'd333333;
      4'd1:    return 19'd83333;
      4'd2:    return 19'd41667;
      4'd3:    return 19'd20833;
      4'd4:    return 19'd10417;
      4'd5:    return 19'd5208;
      4'd6:    return 19'd2604;
      4'd7:    return 19'd1736;
      4'd8:    return 19'd868;
      4'd9:    return 19'd434;
      4'd10:   return 19'd217;
      default: return 19'd109;
    endcase
  endfunction

  function automatic logic parity_f(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // Frame word is transmitted from bit 0 upward; unused tail positions are stop bits.
  function automatic logic [10:0] frame_f(input logic e, input logic p,
                                          input logic o, input logic [7:0] d);
    case ({e, p})
      2'b11:   return {1'b1, parity_f(d, o), d, 1'b0};
      2'b10:   return {2'b11, d, 1'b0};
      2'b01:   return {2'b11, parity_f({1'b0, d[6:0]}, o), d[6:0], 1'b0};
      default: return {3'b111, d[6:0], 1'b0};
    endcase
  endfunction

  assign sel_time_s = bit_time_f(baud);
  assign bit_end_s  = (baud_cnt_q == 19'd0);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= 11'h7FF;
      bit_cnt_q  <= 4'd0;
      baud_cnt_q <= 19'd0;
      bit_time_q <= 19'd0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      bit_time_q <= bit_time_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load) state_d = SHIFT;
        else      state_d = IDLE;
      end
      SHIFT: begin
        if (bit_end_s && (bit_cnt_q == 4'd10)) state_d = IDLE;
        else                                   state_d = SHIFT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: frame capture on accept, bit-time countdown, shifting
  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q;
    bit_time_d = bit_time_q;
    case (state_q)
      IDLE: begin
        if (load) begin
          shift_d    = frame_f(eight, parity_en, odd_n_even, out_port);
          bit_time_d = sel_time_s;
          baud_cnt_d = sel_time_s - 19'd1;
          bit_cnt_d  = 4'd0;
        end else begin
          shift_d    = 11'h7FF;
          baud_cnt_d = 19'd0;
          bit_cnt_d  = 4'd0;
        end
      end
      SHIFT: begin
        if (bit_end_s) begin
          if (bit_cnt_q == 4'd10) begin
            shift_d    = 11'h7FF;
            bit_cnt_d  = 4'd0;
            baud_cnt_d = 19'd0;
          end else begin
            shift_d    = {1'b1, shift_q[10:1]};
            bit_cnt_d  = bit_cnt_q + 4'd1;
            baud_cnt_d = bit_time_q - 19'd1;
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 19'd1;
        end
      end
      default: begin
        shift_d    = 11'h7FF;
        bit_cnt_d  = 4'd0;
        baud_cnt_d = 19'd0;
      end
    endcase
  end

  // Outputs are direct register taps
  always_comb begin
    tx    = shift_q[0];
    txrdy = (state_q == IDLE);
  end

endmodule

// File: tb/tb_transmit_engine.sv
// Scoreboard bench for transmit_engine: stimulus pushes model-built frames,
// a negedge monitor pops and checks every tx sample and the txrdy window.
`timescale 1ns/1ps
module tb_transmit_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] baud = 4'd0;
  logic       eight = 1'b0, parity_en = 1'b0, odd_n_even = 1'b0;
  logic [7:0] out_port = 8'h00;
  logic       load = 1'b0;
  logic       tx, txrdy;

  transmit_engine dut (
    .clk(clk), .reset(reset), .baud(baud), .eight(eight), .parity_en(parity_en),
    .odd_n_even(odd_n_even), .out_port(out_port), .load(load), .tx(tx), .txrdy(txrdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] bits;
    int          t;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   bt_tab[16] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736,
                       868, 434, 217, 109, 109, 109, 109, 109};

  // Reference model: list the bits on the wire from the frame rules
  function automatic exp_t model(input int b, input bit e, input bit p, input bit o,
                                 input logic [7:0] d);
    exp_t r;
    int   n = 0;
    int   ones = 0;
    int   nd = e ? 8 : 7;
    r.bits = 11'h7FF;
    r.bits[n] = 1'b0; n++;
    for (int i = 0; i < nd; i++) begin
      r.bits[n] = d[i]; n++;
      ones += d[i];
    end
    if (p) begin
      r.bits[n] = ((ones % 2) == 1) ^ o; n++;
    end
    r.t = bt_tab[b];
    return r;
  endfunction

  function automatic void check(input string name, input logic [1:0] act, input logic [1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: {tx,txrdy} got %b required %b", name, act, req);
    end
  endfunction

  // Monitor state
  bit         rst_seen = 1'b0, mon_en = 1'b0;
  bit         mon_active = 1'b0, expect_end = 1'b0, bit_err = 1'b0;
  exp_t       cur;
  int         mon_bit = 0, mon_cnt = 0, frame_no = 0;
  logic [1:0] obs;

  always @(posedge clk) begin
    rst_seen <= reset;
    if (reset) mon_en <= 1'b1;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_seen) begin
        mon_active = 1'b0;
        expect_end = 1'b0;
        check("reset_state", {tx, txrdy}, 2'b11);
      end else begin
        if (expect_end) begin
          expect_end = 1'b0;
          check($sformatf("frame%0d_end", frame_no), {tx, txrdy}, 2'b11);
        end else if (!mon_active) begin
          if (tx === 1'b0) begin
            if (q.size() == 0) begin
              check("unexpected_frame", {tx, txrdy}, 2'b11);
              cur.bits = 11'h7FF;
              cur.t = 109;
            end else begin
              cur = q.pop_front();
            end
            frame_no++;
            mon_active = 1'b1;
            mon_bit = 0;
            mon_cnt = 0;
            bit_err = 1'b0;
          end else begin
            check("idle", {tx, txrdy}, 2'b11);
          end
        end
        if (mon_active) begin
          if ({tx, txrdy} !== {cur.bits[mon_bit], 1'b0} && !bit_err) begin
            bit_err = 1'b1;
            obs = {tx, txrdy};
          end
          mon_cnt++;
          if (mon_cnt == cur.t) begin
            if (!bit_err) obs = {tx, txrdy};
            check($sformatf("frame%0d_bit%0d", frame_no, mon_bit), obs, {cur.bits[mon_bit], 1'b0});
            bit_err = 1'b0;
            mon_cnt = 0;
            mon_bit++;
            if (mon_bit == 11) begin
              mon_active = 1'b0;
              expect_end = 1'b1;
            end
          end
        end
      end
    end
  end

  task automatic scramble();
    baud = 4'($urandom);
    eight = 1'($urandom);
    parity_en = 1'($urandom);
    odd_n_even = 1'($urandom);
    out_port = 8'($urandom);
    load = ($urandom_range(0, 99) < 3);
  endtask

  // Called just after a rising edge; returns just after the edge where txrdy rises.
  task automatic send(input int b, input bit e, input bit p, input bit o,
                      input logic [7:0] d, input bit noise);
    int t = bt_tab[b];
    baud = 4'(b); eight = e; parity_en = p; odd_n_even = o; out_port = d;
    load = 1'b1;
    q.push_back(model(b, e, p, o, d));
    @(posedge clk); #1;
    load = 1'b0;
    for (int c = 1; c < 11 * t; c++) begin
      @(posedge clk); #1;
      if (noise) scramble();
    end
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Abort a frame with reset during data bit 3.
  task automatic reset_mid(input int b, input bit e, input bit p, input bit o,
                           input logic [7:0] d);
    int t = bt_tab[b];
    baud = 4'(b); eight = e; parity_en = p; odd_n_even = o; out_port = d;
    load = 1'b1;
    q.push_back(model(b, e, p, o, d));
    @(posedge clk); #1;
    load = 1'b0;
    for (int c = 1; c < 4 * t + t / 2; c++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    send(11, 1'b1, 1'b1, 1'b1, 8'h0F, 1'b0);
    send(11, 1'b0, 1'b0, 1'b0, 8'hC5, 1'b0);
    send(11, 1'b1, 1'b1, 1'b0, 8'h01, 1'b0);
    send(11, 1'b1, 1'b1, 1'b0, 8'h03, 1'b1);
    send(9, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1);
    reset_mid(11, 1'b1, 1'b1, 1'b1, 8'hA5);
    send(11, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b0);
    // reset wins over a simultaneous load
    reset = 1'b1; load = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; load = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      int b = ($urandom_range(0, 9) < 7) ? $urandom_range(11, 15) : 10;
      send(b, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (q.size() != 0 || mon_active || expect_end) begin
      n_fail++;
      $display("FAIL drain: pending frames %0d active %0b required 0 0", q.size(), mon_active);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
